// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared types and sizes for the 32-bit word FIFO and its drain.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam int DATA_W   = 32;
  localparam int BYTE_W   = 8;
  localparam int NBYTES   = DATA_W / BYTE_W;
  localparam int WCOUNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_unpacker
// Brief    : Pops one FIFO word at a time and emits it as a valid/ready
//            byte stream, LSB-first or MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_unpacker #(
  parameter int DATA_W    = fifo_pkg::DATA_W,
  parameter int BYTE_W    = fifo_pkg::BYTE_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          EN,
  input  logic                          flush,
  input  logic                          fifo_empty,
  output logic                          fifo_rd,
  input  logic [DATA_W-1:0]             fifo_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [BYTE_W-1:0]             m_data,
  output logic                          m_last,
  output logic                          busy,
  output logic [fifo_pkg::WCOUNT_W-1:0] word_count
);

  import fifo_pkg::*;

  localparam int                 c_nbytes   = DATA_W / BYTE_W;
  localparam int                 c_idx_w    = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nbytes - 1);

  if ((DATA_W % BYTE_W) != 0) begin : g_width_check
    $error("fifo_word_unpacker: DATA_W must be a whole number of BYTE_W bytes");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_W-1:0]     r_word;
  logic [DATA_W-1:0]     w_word_nxt;
  logic [c_idx_w-1:0]    r_idx;
  logic [c_idx_w-1:0]    w_idx_nxt;
  logic [WCOUNT_W-1:0]   r_word_count;
  logic [WCOUNT_W-1:0]   w_count_nxt;
  logic                  r_fifo_rd;
  logic                  r_m_valid;
  logic [BYTE_W-1:0]     r_m_data;
  logic                  r_m_last;
  logic [BYTE_W-1:0]     w_m_data_nxt;
  logic                  w_send_nxt;

  // Byte lane for a given transmit slot; MSB_FIRST reverses slot order.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [DATA_W-1:0] word,
                                                 input logic [c_idx_w-1:0] idx);
    int                pos;
    logic [DATA_W-1:0] shifted;
    pos     = MSB_FIRST ? (c_nbytes - 1 - int'(idx)) : int'(idx);
    shifted = word >> (pos * BYTE_W);
    return shifted[BYTE_W-1:0];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_idx_nxt   = r_idx;
    w_count_nxt = r_word_count;
    if (flush) begin
      w_state_nxt = IDLE;
      w_word_nxt  = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (EN && !fifo_empty) begin
            w_state_nxt = REQ;
          end
        end
        REQ: begin
          w_state_nxt = CAP;
        end
        CAP: begin
          w_word_nxt  = fifo_data;
          w_idx_nxt   = '0;
          w_state_nxt = SEND;
        end
        SEND: begin
          // m_valid is always high in SEND, so m_ready alone completes a beat.
          if (m_ready) begin
            if (r_idx == c_last_idx) begin
              w_count_nxt = r_word_count + 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
    w_send_nxt   = (w_state_nxt == SEND);
    w_m_data_nxt = w_send_nxt ? byte_sel(w_word_nxt, w_idx_nxt) : '0;
  end

  // Outputs are precomputed from next-state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_word       <= '0;
      r_idx        <= '0;
      r_word_count <= '0;
      r_fifo_rd    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_word       <= w_word_nxt;
      r_idx        <= w_idx_nxt;
      r_word_count <= w_count_nxt;
      r_fifo_rd    <= (w_state_nxt == REQ);
      r_m_valid    <= w_send_nxt;
      r_m_data     <= w_m_data_nxt;
      r_m_last     <= w_send_nxt && (w_idx_nxt == c_last_idx);
    end
  end

  assign fifo_rd    = r_fifo_rd;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign busy       = (r_state != IDLE);
  assign word_count = r_word_count;

endmodule
`default_nettype wire
